// File: rtl/rsa_tx_scheduler.sv
// Arbitrates buffered RSA encrypt/decrypt result bytes onto the UART TX AXI-stream.
// Optional TX_TAG_HEADER_EN: each result is preceded by a tag beat ('E' or 'D').
module rsa_tx_scheduler #(
   parameter int DATA_W     = 8,
   parameter bit SEND_GATED = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enc_valid,
   input  logic [DATA_W-1:0] enc_data,
   input  logic              dec_valid,
   input  logic [DATA_W-1:0] dec_data,
   input  logic              send,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic              busy,
   output logic              overrun
);

`ifdef TX_TAG_HEADER_EN
   typedef enum logic [2:0] {IDLE, SEND_ENC, SEND_DEC, TAG_ENC, TAG_DEC} state_t;
   localparam logic [DATA_W-1:0] TAG_E = DATA_W'(8'h45);
   localparam logic [DATA_W-1:0] TAG_D = DATA_W'(8'h44);
`else
   typedef enum logic [1:0] {IDLE, SEND_ENC, SEND_DEC} state_t;
`endif

   state_t            state, state_nxt;
   logic [DATA_W-1:0] tdata_nxt;
   logic              tvalid_nxt;
   logic [DATA_W-1:0] enc_buf, dec_buf;
   logic              enc_full, dec_full;
   logic              enc_new, dec_new;
   logic              send_q, send_pend;
   logic              send_edge, beat_done, dec_ready;
   logic              enc_consume, dec_consume;
   logic              enc_launch, dec_launch;

   assign send_edge   = send & ~send_q;
   assign beat_done   = m_axis_tvalid & m_axis_tready;
   assign dec_ready   = dec_full & (send_pend | ~SEND_GATED);
   assign enc_consume = beat_done & (state == SEND_ENC);
   assign dec_consume = beat_done & (state == SEND_DEC);
   // A launch is the cycle the buffered byte is copied onto the bus.
   assign enc_launch  = (state_nxt == SEND_ENC) & (state != SEND_ENC);
   assign dec_launch  = (state_nxt == SEND_DEC) & (state != SEND_DEC);
   assign busy        = (state != IDLE) | enc_full | dec_full;

   always_comb begin
      state_nxt  = state;
      tdata_nxt  = m_axis_tdata;
      tvalid_nxt = m_axis_tvalid;
      case (state)
         IDLE: begin
            if (enc_full) begin
`ifdef TX_TAG_HEADER_EN
               state_nxt = TAG_ENC;
               tdata_nxt = TAG_E;
`else
               state_nxt = SEND_ENC;
               tdata_nxt = enc_buf;
`endif
               tvalid_nxt = 1'b1;
            end else if (dec_ready) begin
`ifdef TX_TAG_HEADER_EN
               state_nxt = TAG_DEC;
               tdata_nxt = TAG_D;
`else
               state_nxt = SEND_DEC;
               tdata_nxt = dec_buf;
`endif
               tvalid_nxt = 1'b1;
            end
         end
`ifdef TX_TAG_HEADER_EN
         TAG_ENC: begin
            if (beat_done) begin
               state_nxt = SEND_ENC;
               tdata_nxt = enc_buf;
            end
         end
         TAG_DEC: begin
            if (beat_done) begin
               state_nxt = SEND_DEC;
               tdata_nxt = dec_buf;
            end
         end
`endif
         SEND_ENC, SEND_DEC: begin
            if (beat_done) begin
               state_nxt  = IDLE;
               tvalid_nxt = 1'b0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // enc_new/dec_new mark a byte not yet copied to the bus, so a byte that
   // overwrote an in-flight one keeps the buffer full after the handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         enc_full      <= 1'b0;
         dec_full      <= 1'b0;
         enc_new       <= 1'b0;
         dec_new       <= 1'b0;
         send_q        <= 1'b0;
         send_pend     <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         state         <= state_nxt;
         m_axis_tvalid <= tvalid_nxt;
         m_axis_tdata  <= tdata_nxt;
         enc_full      <= enc_valid | (enc_consume ? enc_new : enc_full);
         dec_full      <= dec_valid | (dec_consume ? dec_new : dec_full);
         enc_new       <= enc_valid | (enc_new & ~enc_launch);
         dec_new       <= dec_valid | (dec_new & ~dec_launch);
         send_q        <= send;
         send_pend     <= send_pend ? ~dec_consume : send_edge;
         overrun       <= overrun | (enc_valid & enc_full & ~enc_consume)
                                  | (dec_valid & dec_full & ~dec_consume);
      end
   end

   always_ff @(posedge clk) begin
      if (enc_valid) enc_buf <= enc_data;
      if (dec_valid) dec_buf <= dec_data;
   end

endmodule

// File: tb/tb_rsa_tx_scheduler.sv
// Bench for rsa_tx_scheduler: directed scenarios plus randomized traffic
// against a transaction-level model of pending bytes and the bytes on the bus.
module tb_rsa_tx_scheduler;
   localparam bit GATED = 1'b1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enc_valid = 1'b0, dec_valid = 1'b0, send = 1'b0;
   logic [7:0] enc_data = 8'h00, dec_data = 8'h00;
   logic [7:0] m_axis_tdata;
   logic       m_axis_tvalid;
   logic       m_axis_tready = 1'b0;
   logic       busy, overrun;

   int checks = 0;
   int errors = 0;
   logic [7:0] beats[$];

   // model: bytes waiting to be put on the bus, and the beat currently on it
   logic [7:0] me_buf, md_buf, m_td;
   bit me_pend, md_pend, m_sendreq, m_sprev, m_ovr;
   bit m_fly, m_fsrc, m_ftag, m_tv;

   rsa_tx_scheduler #(.DATA_W(8), .SEND_GATED(GATED)) dut (
      .clk(clk), .rst(rst),
      .enc_valid(enc_valid), .enc_data(enc_data),
      .dec_valid(dec_valid), .dec_data(dec_data),
      .send(send),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      me_buf = 0; md_buf = 0; m_td = 0;
      me_pend = 0; md_pend = 0; m_sendreq = 0; m_sprev = 0; m_ovr = 0;
      m_fly = 0; m_fsrc = 0; m_ftag = 0; m_tv = 0;
   endtask

   task automatic capture(input bit src);
      m_td = src ? md_buf : me_buf;
      if (src) md_pend = 0; else me_pend = 0;
   endtask

   task automatic launch(input bit src);
      m_fly = 1; m_fsrc = src; m_tv = 1;
`ifdef TX_TAG_HEADER_EN
      m_ftag = 1;
      m_td = src ? 8'h44 : 8'h45;
`else
      capture(src);
`endif
   endtask

   task automatic model_tick();
      bit hs, dhs, fly0, src0, ep0, dp0, edge_s;
      hs = m_tv && m_axis_tready;
      dhs = hs && m_fly && !m_ftag;
      fly0 = m_fly; src0 = m_fsrc; ep0 = me_pend; dp0 = md_pend;
      edge_s = send && !m_sprev;
      if (m_fly) begin
         if (hs && m_ftag) begin
            m_ftag = 0;
            capture(m_fsrc);
         end else if (hs) begin
            m_fly = 0;
            m_tv = 0;
         end
      end else if (me_pend) begin
         launch(1'b0);
      end else if (md_pend && (m_sendreq || !GATED)) begin
         launch(1'b1);
      end
      if (m_sendreq) begin
         if (dhs && src0) m_sendreq = 0;
      end else if (edge_s) begin
         m_sendreq = 1;
      end
      if (enc_valid) begin
         if ((ep0 || (fly0 && !src0)) && !(dhs && !src0)) m_ovr = 1;
         me_buf = enc_data; me_pend = 1;
      end
      if (dec_valid) begin
         if ((dp0 || (fly0 && src0)) && !(dhs && src0)) m_ovr = 1;
         md_buf = dec_data; md_pend = 1;
      end
      m_sprev = send;
   endtask

   // one clock: log handshake, advance model, compare after the edge
   task automatic step();
      if (m_axis_tvalid && m_axis_tready) beats.push_back(m_axis_tdata);
      if (rst) model_reset(); else model_tick();
      @(posedge clk);
      #1;
      chk("tvalid", 8'(m_axis_tvalid), 8'(m_tv));
      if (m_tv) chk("tdata", m_axis_tdata, m_td);
      chk("busy", 8'(busy), 8'(m_fly || me_pend || md_pend));
      chk("overrun", 8'(overrun), 8'(m_ovr));
   endtask

   task automatic chk_beats(input string tag, input int n, input logic [7:0] b0,
                            input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
      logic [7:0] e[4];
      e[0] = b0; e[1] = b1; e[2] = b2; e[3] = b3;
      chk({tag, "_count"}, 8'(beats.size()), 8'(n));
      for (int i = 0; i < n; i++)
         chk(tag, (i < beats.size()) ? beats[i] : 8'h00, e[i]);
      beats.delete();
   endtask

   initial begin
      model_reset();
      repeat (2) step();
      chk("rst_tvalid", 8'(m_axis_tvalid), 8'h00);
      chk("rst_tdata", m_axis_tdata, 8'h00);
      chk("rst_busy", 8'(busy), 8'h00);
      chk("rst_overrun", 8'(overrun), 8'h00);
      rst = 0;
      step();

      // latency and backpressure
      m_axis_tready = 0;
      enc_valid = 1; enc_data = 8'h11; step(); enc_valid = 0;
      chk("lat_n1_tvalid", 8'(m_axis_tvalid), 8'h00);
      chk("lat_n1_busy", 8'(busy), 8'h01);
      step();
      chk("lat_n2_tvalid", 8'(m_axis_tvalid), 8'h01);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("bp_tvalid", 8'(m_axis_tvalid), 8'h01);
         chk("bp_tdata", m_axis_tdata, 8'h11);
      end
      m_axis_tready = 1;
      repeat (4) step();
      chk_beats("bp_beats", 1, 8'h11, 8'h00, 8'h00, 8'h00);

      // asynchronous reset while a beat is in flight
      m_axis_tready = 0;
      enc_valid = 1; enc_data = 8'h22; step(); enc_valid = 0;
      step();
      chk("pre_rst_tvalid", 8'(m_axis_tvalid), 8'h01);
      rst = 1;
      #1;
      chk("midrst_tvalid", 8'(m_axis_tvalid), 8'h00);
      chk("midrst_tdata", m_axis_tdata, 8'h00);
      chk("midrst_busy", 8'(busy), 8'h00);
      step();
      rst = 0; m_axis_tready = 1;
      repeat (5) step();
      chk_beats("midrst_beats", 0, 8'h00, 8'h00, 8'h00, 8'h00);

      // priority: encrypted before a send-released decrypted byte
      dec_valid = 1; dec_data = 8'h5A; step(); dec_valid = 0;
      send = 1; enc_valid = 1; enc_data = 8'h3C; step(); enc_valid = 0; send = 0;
      repeat (8) step();
      chk_beats("prio_beats", 2, 8'h3C, 8'h5A, 8'h00, 8'h00);

      // send gating
      dec_valid = 1; dec_data = 8'hA5; step(); dec_valid = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         chk("gate_tvalid", 8'(m_axis_tvalid), 8'h00);
      end
      chk("gate_busy", 8'(busy), 8'h01);
      send = 1; step(); send = 0;
      chk("gate_edge_tvalid", 8'(m_axis_tvalid), 8'h00);
      step();
      chk("gate_rel_tvalid", 8'(m_axis_tvalid), 8'h01);
      chk("gate_rel_tdata", m_axis_tdata, 8'hA5);
      repeat (3) step();
      chk_beats("gate_beats", 1, 8'hA5, 8'h00, 8'h00, 8'h00);

      // overrun while in flight
      chk("ovr_before", 8'(overrun), 8'h00);
      m_axis_tready = 0;
      enc_valid = 1; enc_data = 8'h01; step(); enc_valid = 0;
      step();
      enc_valid = 1; enc_data = 8'h02; step();
      enc_data = 8'h03; step(); enc_valid = 0;
      chk("ovr_set", 8'(overrun), 8'h01);
      chk("ovr_inflight_tdata", m_axis_tdata, 8'h01);
      m_axis_tready = 1;
      repeat (6) step();
      chk_beats("ovr_beats", 2, 8'h01, 8'h03, 8'h00, 8'h00);
      chk("ovr_sticky", 8'(overrun), 8'h01);
      rst = 1; step(); rst = 0;
      chk("ovr_cleared", 8'(overrun), 8'h00);

      // back-to-back results (tag beats when the header option is built)
      enc_valid = 1; enc_data = 8'h77; step(); enc_valid = 0;
      dec_valid = 1; dec_data = 8'h88; send = 1; step(); dec_valid = 0; send = 0;
      repeat (10) step();
`ifdef TX_TAG_HEADER_EN
      chk_beats("tag_beats", 4, 8'h45, 8'h77, 8'h44, 8'h88);
`else
      chk_beats("pair_beats", 2, 8'h77, 8'h88, 8'h00, 8'h00);
`endif

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         enc_valid = ($urandom_range(0, 9) == 0);
         enc_data = 8'($urandom);
         dec_valid = ($urandom_range(0, 9) == 0);
         dec_data = 8'($urandom);
         if ($urandom_range(0, 3) == 0) send = ~send;
         m_axis_tready = ($urandom_range(0, 2) != 0);
         rst = (i == 1500);
         step();
      end
      rst = 0; enc_valid = 0; dec_valid = 0; send = 0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
